// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - RV32M EX-stage iterative multiply/divide unit with pipeline busywait
// Optional single-cycle multiplier when FAST_MUL_EN is defined.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            start,
    input  logic [4:0]      aluop,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            stall_in,
    input  logic            flush,
    output logic            busywait,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic        sign_q, sign_d, rsign_q, rsign_d;
    logic [63:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [31:0] opb_q, opb_d, quot_q, quot_d, result_q, result_d;
    logic [32:0] rem_q, rem_d;

    logic [2:0]  f3;
    logic        m, sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
    logic [31:0] abs_a, abs_b;
    logic [63:0] prod_nxt, prod_fin;
    logic [31:0] mul_res, quot_nxt, q_fin, r_fin, div_res;
    logic [32:0] shl, diff, rem_nxt;
    logic        ge;
    logic        unused_bits;

    assign f3    = aluop[2:0];
    assign m     = start & aluop[4];
    assign sgn_a = (f3 == 3'b001) | (f3 == 3'b010) | (f3 == 3'b100) | (f3 == 3'b110);
    assign sgn_b = (f3 == 3'b001) | (f3 == 3'b100) | (f3 == 3'b110);
    assign neg_a = sgn_a & op_a[31];
    assign neg_b = sgn_b & op_b[31];
    assign abs_a = neg_a ? (~op_a + 32'd1) : op_a;
    assign abs_b = neg_b ? (~op_b + 32'd1) : op_b;
    assign div_zero = (op_b == 32'd0);
    assign div_ovf  = f3[2] & ~f3[0] & (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);

    // One shift-add step; the final step's sum feeds the result directly.
    assign prod_nxt = acc_q + (opb_q[0] ? mcand_q : 64'd0);
    assign prod_fin = sign_q ? (~prod_nxt + 64'd1) : prod_nxt;
    assign mul_res  = (f3_q == 3'b000) ? prod_fin[31:0] : prod_fin[63:32];

    // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
    assign shl      = {rem_q[31:0], quot_q[31]};
    assign diff     = shl - {1'b0, opb_q};
    assign ge       = (shl >= {1'b0, opb_q});
    assign rem_nxt  = ge ? diff : shl;
    assign quot_nxt = {quot_q[30:0], ge};
    assign q_fin    = sign_q ? (~quot_nxt + 32'd1) : quot_nxt;
    assign r_fin    = rsign_q ? (~rem_nxt[31:0] + 32'd1) : rem_nxt[31:0];
    assign div_res  = f3_q[1] ? r_fin : q_fin;

`ifdef FAST_MUL_EN
    logic signed [65:0] fprod;
    logic [31:0]        fast_res;
    assign fprod    = $signed({neg_a, op_a}) * $signed({neg_b, op_b});
    assign fast_res = (f3 == 3'b000) ? fprod[31:0] : fprod[63:32];
    assign unused_bits = ^{aluop[3], rem_q[32], fprod[65:64]};
`else
    assign unused_bits = ^{aluop[3], rem_q[32]};
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        sign_d   = sign_q;
        rsign_d  = rsign_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        opb_d    = opb_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (m) begin
                    f3_d    = f3;
                    sign_d  = neg_a ^ neg_b;
                    rsign_d = neg_a;
                    cnt_d   = 6'd0;
                    if (f3[2]) begin
                        if (div_zero) begin
                            result_d = f3[1] ? op_a : 32'hFFFF_FFFF;
                            state_d  = S_DONE;
                        end else if (div_ovf) begin
                            result_d = f3[1] ? 32'd0 : 32'h8000_0000;
                            state_d  = S_DONE;
                        end else begin
                            rem_d   = 33'd0;
                            quot_d  = abs_a;
                            opb_d   = abs_b;
                            state_d = S_DIV;
                        end
                    end else begin
`ifdef FAST_MUL_EN
                        result_d = fast_res;
                        state_d  = S_DONE;
`else
                        acc_d   = 64'd0;
                        mcand_d = {32'd0, abs_a};
                        opb_d   = abs_b;
                        state_d = S_MUL;
`endif
                    end
                end
            end
            S_MUL: begin
                acc_d   = prod_nxt;
                mcand_d = mcand_q << 1;
                opb_d   = opb_q >> 1;
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == 6'(ITERS - 1)) begin
                    result_d = mul_res;
                    state_d  = S_DONE;
                end
            end
            S_DIV: begin
                rem_d  = rem_nxt;
                quot_d = quot_nxt;
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == 6'(ITERS - 1)) begin
                    result_d = div_res;
                    state_d  = S_DONE;
                end
            end
            default: begin
                // start still names the finished instruction here, so it is not looked at
                if (!stall_in) state_d = S_IDLE;
            end
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            f3_q     <= 3'd0;
            sign_q   <= 1'b0;
            rsign_q  <= 1'b0;
            acc_q    <= 64'd0;
            mcand_q  <= 64'd0;
            opb_q    <= 32'd0;
            quot_q   <= 32'd0;
            rem_q    <= 33'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            sign_q   <= sign_d;
            rsign_q  <= rsign_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            opb_q    <= opb_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign busywait = ~reset & (((state_q == S_IDLE) & m) | (state_q == S_MUL) | (state_q == S_DIV));
    assign done     = (state_q == S_DONE);
    assign result   = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed table-driven bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

    logic        CLK = 1'b0;
    logic        reset, start, stall_in, flush;
    logic [4:0]  aluop;
    logic [31:0] op_a, op_b;
    logic        busywait, done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    ex_muldiv_unit dut (
        .CLK(CLK), .reset(reset), .start(start), .aluop(aluop),
        .op_a(op_a), .op_b(op_b), .stall_in(stall_in), .flush(flush),
        .busywait(busywait), .done(done), .result(result)
    );

`ifdef FAST_MUL_EN
    localparam int MUL_BUSY = 1;
`else
    localparam int MUL_BUSY = 33;
`endif

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          busy;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op at #1 after a posedge; returns busy cycle count and the done-cycle result.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output int busy, output logic [31:0] res, output logic got_done);
        busy = 0; got_done = 1'b0; res = 32'hxxxx_xxxx;
        start = 1'b1; aluop = {2'b10, f3}; op_a = a; op_b = b;
        @(negedge CLK);
        if (busywait) busy++;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (done) begin
                got_done = 1'b1;
                res = result;
                break;
            end
            if (busywait) busy++;
            @(posedge CLK); #1;
        end
        @(posedge CLK); #1;
    endtask

    int          busy, cnt;
    logic [31:0] res, last;
    logic        got;

    initial begin
        vecs[0]  = '{"mul_7_m3",     3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_BUSY};
        vecs[1]  = '{"mulh_min",     3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_BUSY};
        vecs[2]  = '{"mulhu_max",    3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_BUSY};
        vecs[3]  = '{"mulhsu_max",   3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_BUSY};
        vecs[4]  = '{"mul_lo_2p32",  3'b000, 32'h0001_0000,  32'h0001_0000, 32'd0,         MUL_BUSY};
        vecs[5]  = '{"mulhu_2p32",   3'b011, 32'h0001_0000,  32'h0001_0000, 32'd1,         MUL_BUSY};
        vecs[6]  = '{"div_m7_2",     3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[7]  = '{"rem_m7_2",     3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[8]  = '{"divu_100_7",   3'b101, 32'd100,        32'd7,         32'd14,        33};
        vecs[9]  = '{"remu_100_7",   3'b111, 32'd100,        32'd7,         32'd2,         33};
        vecs[10] = '{"rem_7_m2",     3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         33};
        vecs[11] = '{"divu_max_1",   3'b101, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33};
        vecs[12] = '{"div_5_0",      3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[13] = '{"remu_5_0",     3'b111, 32'd5,          32'd0,         32'd5,         1};
        vecs[14] = '{"div_ovf",      3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[15] = '{"rem_ovf",      3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};

        // Reset: busywait forced low even with an M-op presented
        reset = 1'b1; start = 1'b1; aluop = 5'b10000; op_a = 32'd7; op_b = 32'd3;
        stall_in = 1'b0; flush = 1'b0;
        @(negedge CLK);
        chk("reset_busywait", {31'd0, busywait}, 32'd0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        @(posedge CLK); #1;
        reset = 1'b0; start = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].f3, vecs[i].a, vecs[i].b, busy, res, got);
            chk({vecs[i].name, "_done_seen"}, {31'd0, got}, 32'd1);
            chk({vecs[i].name, "_result"}, res, vecs[i].exp);
            chk({vecs[i].name, "_busy"}, busy, vecs[i].busy);
            @(negedge CLK);
            chk({vecs[i].name, "_single_done"}, {31'd0, done}, 32'd0);
            @(posedge CLK); #1;
        end
        last = vecs[15].exp;

        // Non-M aluop: nothing happens, result holds
        start = 1'b1; aluop = 5'b00011; op_a = 32'd9; op_b = 32'd9;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (busywait || done || result !== last) cnt++;
            @(posedge CLK); #1;
        end
        start = 1'b0;
        chk("nonm_quiet", cnt, 0);

        // Stall in DONE for 3 cycles: done held for 4 cycles, one completion
        start = 1'b1; aluop = 5'b10101; op_a = 32'd100; op_b = 32'd7;
        @(posedge CLK); #1;
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            if (done) begin got = 1'b1; break; end
        end
        chk("stall_done_seen", {31'd0, got}, 32'd1);
        stall_in = 1'b1;
        cnt = 1;
        for (int k = 0; k < 8; k++) begin
            @(posedge CLK); #1;
            if (k == 2) stall_in = 1'b0;
            @(negedge CLK);
            if (done) begin
                cnt++;
                chk("stall_result_held", result, 32'd14);
            end
        end
        chk("stall_done_cycles", cnt, 4);
        @(posedge CLK); #1;

        // Flush at cycle 10 of a DIV
        start = 1'b1; aluop = 5'b10100; op_a = 32'd1000; op_b = 32'd3;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            @(posedge CLK); #1;
        end
        flush = 1'b1;
        @(negedge CLK);
        chk("flush_c10_busy", {31'd0, busywait}, 32'd1);
        @(posedge CLK); #1;
        flush = 1'b0;
        @(negedge CLK);
        chk("flush_c11_busy", {31'd0, busywait}, 32'd0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (done || busywait) cnt++;
        end
        chk("flush_no_done", cnt, 0);
        chk("flush_result_held", result, 32'd14);
        @(posedge CLK); #1;

        // Flush together with an issuing M-op: the op never starts
        start = 1'b1; flush = 1'b1; aluop = 5'b10000; op_a = 32'd3; op_b = 32'd5;
        @(posedge CLK); #1;
        start = 1'b0; flush = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (done || busywait) cnt++;
        end
        chk("flush_idle_nostart", cnt, 0);
        @(posedge CLK); #1;

        // Reset at cycle 5 of a MUL: abandoned, result cleared
        start = 1'b1; aluop = 5'b10000; op_a = 32'd6; op_b = 32'd7;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int k = 1; k < 5; k++) begin
            @(posedge CLK); #1;
        end
        reset = 1'b1;
        @(negedge CLK);
        chk("rst_mid_busy_forced", {31'd0, busywait}, 32'd0);
        @(posedge CLK); #1;
        reset = 1'b0;
        @(negedge CLK);
        chk("rst_mid_result", result, 32'd0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (done || busywait) cnt++;
        end
        chk("rst_mid_idle", cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
